// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_pkg
// Description : Shared definitions for the bit-serial adder/subtractor:
//               FSM state encodings, operation mode constants and the
//               default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_addsub_pkg
`default_nettype wire

// File: rtl/full_addsub_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_addsub_bit
// Description : 1-bit full adder / full subtractor cell.
//               Ports:
//                 a, b    - operand bits
//                 cb_in   - incoming carry (add) or borrow (subtract)
//                 mode    - MODE_ADD / MODE_SUB
//                 s       - sum / difference bit
//                 cb_out  - outgoing carry (add) or borrow (subtract)
// Revision    : 1.0 - initial release
// ============================================================================
module full_addsub_bit
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cb_in,
    input  logic mode,
    output logic s,
    output logic cb_out
);

    logic w_carry;
    logic w_borrow;

    // Sum and difference bits are the same three-way XOR; only the
    // carry/borrow generation differs between the two modes.
    assign s        = a ^ b ^ cb_in;
    assign w_carry  = (a & b) | ((a ^ b) & cb_in);
    assign w_borrow = (~a & b) | (~(a ^ b) & cb_in);
    assign cb_out   = (mode == MODE_SUB) ? w_borrow : w_carry;

endmodule : full_addsub_bit
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial unsigned adder/subtractor. Operands are latched
//               on an accepted start, processed LSB first one bit per clock
//               through a single full_addsub_bit cell, and the result is
//               published with a one-cycle done pulse.
//               Ports:
//                 clk_in      - clock, rising edge
//                 rst_n_in    - synchronous active-low reset
//                 start_in    - start request (sampled only when idle)
//                 mode_in     - 0 = a+b, 1 = a-b
//                 a_in, b_in  - unsigned operands
//                 busy_out    - operation in progress
//                 done_out    - one-cycle pulse when result is updated
//                 result_out  - result, held until the next completion
//                 cb_out      - final carry (add) / borrow (subtract)
//                 ovf_out     - signed overflow (SERIAL_ADDSUB_OVF_EN only)
//               Build option: define SERIAL_ADDSUB_OVF_EN to add ovf_out.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             cb_out
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int              c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_mode;
    logic               r_cb;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   r_result;
    logic               r_cb_out;
    logic               r_done;

    logic               w_s;
    logic               w_cb;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST);

    full_addsub_bit u_cell (
        .a      (r_a[0]),
        .b      (r_b[0]),
        .cb_in  (r_cb),
        .mode   (r_mode),
        .s      (w_s),
        .cb_out (w_cb)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_in) w_next_state = RUN;
            RUN:     if (w_last)   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
`ifdef SERIAL_ADDSUB_OVF_EN
    logic r_ovf_calc;
    logic r_ovf;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= MODE_ADD;
            r_cb     <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_result <= '0;
            r_cb_out <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            r_ovf_calc <= 1'b0;
            r_ovf      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_a    <= a_in;
                        r_b    <= b_in;
                        r_mode <= mode_in;
                        r_cb   <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    // Operands shift toward bit 0; each new result bit
                    // enters at the MSB so the LSB lands at bit 0 after
                    // WIDTH shifts.
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_sum <= {w_s, r_sum[WIDTH-1:1]};
                    r_cb  <= w_cb;
                    r_cnt <= r_cnt + 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
                    // Signed overflow is carry-in XOR carry-out of the
                    // MSB; for subtraction the borrows are inverted
                    // carries, so the same XOR applies.
                    if (w_last) begin
                        r_ovf_calc <= r_cb ^ w_cb;
                    end
`endif
                end
                DONE: begin
                    r_result <= r_sum;
                    r_cb_out <= r_cb;
                    r_done   <= 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
                    r_ovf    <= r_ovf_calc;
`endif
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy_out   = (r_state != IDLE);
    assign done_out   = r_done;
    assign result_out = r_result;
    assign cb_out     = r_cb_out;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf_out    = r_ovf;
`endif

endmodule : serial_addsub
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub (WIDTH = 8). Expected
//               results come from plain integer arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         start_in;
    logic         mode_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] result_out;
    logic         cb_out;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .start_in   (start_in),
        .mode_in    (mode_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .result_out (result_out),
        .cb_out     (cb_out)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf_out    (ovf_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic on whole numbers, not bit-serial.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                  output logic [W-1:0] r, output logic cb, output logic ov);
        int ua, ub, sa, sb, ures, sres;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (m == 1'b0) begin
            ures = ua + ub;
            sres = sa + sb;
            cb   = (ures >= 256);
        end else begin
            ures = ua - ub;
            sres = sa - sb;
            cb   = (ua < ub);
        end
        r  = W'(ures & 255);
        ov = (sres > 127) || (sres < -128);
    endfunction

    // Issues one operation starting at a negedge. disturb: 0 = quiet inputs,
    // 1 = random start/operand noise while running, 2 = start pulse with
    // a_in = 0xAA in running cycle 3.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input int disturb);
        logic [W-1:0] er;
        logic ecb, eov;
        int done_k, n_done, n_busy;
        model(a, b, m, er, ecb, eov);
        a_in = a; b_in = b; mode_in = m; start_in = 1'b1;
        @(posedge clk_in);
        done_k = -1; n_done = 0; n_busy = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            if (disturb == 1 && k <= 8) begin
                start_in = 1'($urandom);
                a_in     = W'($urandom);
                b_in     = W'($urandom);
                mode_in  = 1'($urandom);
            end else if (disturb == 2 && k == 3) begin
                start_in = 1'b1;
                a_in     = 8'hAA;
            end
            if (busy_out === 1'b1) n_busy++;
            if (done_out === 1'b1) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (k == 10) begin
                chk("result", result_out, er);
                chk("cb", cb_out, ecb);
`ifdef SERIAL_ADDSUB_OVF_EN
                chk("ovf", ovf_out, eov);
`endif
            end
            if (k == 14) begin
                chk("result_held", result_out, er);
                chk("cb_held", cb_out, ecb);
            end
        end
        chk("done_latency", done_k, 10);
        chk("done_count", n_done, 1);
        chk("busy_cycles", n_busy, 9);
    endtask

    initial begin
        int n_done;
        int t[3];
        rst_n_in = 1'b0; start_in = 1'b0; mode_in = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_done", done_out, 1'b0);
        chk("rst_result", result_out, 8'h00);
        chk("rst_cb", cb_out, 1'b0);
        rst_n_in = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'h05, 8'h03, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b1, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 0);
        run_op(8'h00, 8'h00, 1'b0, 0);
        run_op(8'h01, 8'h01, 1'b0, 2);
        run_op(8'h03, 8'h05, 1'b1, 0);

        // Reset in the fourth running cycle aborts without a done pulse.
        a_in = 8'h10; b_in = 8'h20; mode_in = 1'b0; start_in = 1'b1;
        @(posedge clk_in);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            if (k == 4) rst_n_in = 1'b0;
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        chk("abort_busy", busy_out, 1'b0);
        chk("abort_result", result_out, 8'h00);
        chk("abort_cb", cb_out, 1'b0);
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (done_out === 1'b1) n_done++;
            @(negedge clk_in);
        end
        chk("abort_no_done", n_done, 0);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        a_in = 8'h12; b_in = 8'h34; mode_in = 1'b0; start_in = 1'b1;
        n_done = 0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk_in);
            if (k == 21) start_in = 1'b0;
            if (done_out === 1'b1) begin
                if (n_done < 3) t[n_done] = k;
                n_done++;
                chk("b2b_result", result_out, 8'h46);
            end
        end
        chk("b2b_count", n_done, 3);
        chk("b2b_first", t[0], 10);
        chk("b2b_gap1", t[1] - t[0], 10);
        chk("b2b_gap2", t[2] - t[1], 10);

        for (int i = 0; i < 25; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_addsub
`default_nettype wire

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n_in  input  1  reset, synchronous, active-low.
REQ-004 start_in  input  1  request a new operation; sampled only in IDLE.
REQ-005 mode_in  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start_in.
REQ-006 a_in  input  WIDTH  operand A, unsigned; sampled with start_in.
REQ-007 b_in  input  WIDTH  operand B, unsigned; sampled with start_in.
REQ-008 busy_out  output  1  high while an operation is in progress.
REQ-009 done_out  output  1  single-cycle pulse when result_out and cb_out become valid.
REQ-010 result_out  output  WIDTH  sum or difference, held until the next accepted start.
REQ-011 cb_out  output  1  final carry (add) or final borrow (subtract), held with result_out.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE with start_in=1 SHALL latch a_in, b_in and mode_in, clear the carry/borrow flop and the bit counter, and go to RUN.
REQ-014 RUN SHALL process one bit per cycle, LSB first, through a 1-bit full add/subtract cell, shifting the result bit into the result register MSB-side.
REQ-015 RUN SHALL last exactly WIDTH cycles, then go to DONE.
REQ-016 DONE SHALL last one cycle, assert done_out, update result_out and cb_out, then return to IDLE.
REQ-017 Latency: for start accepted at edge N, done_out SHALL be high in the cycle after edge N+WIDTH+1.
REQ-018 busy_out SHALL be high in RUN and DONE and low in IDLE.
REQ-019 start_in while busy_out=1 SHALL be ignored with no queuing; a_in, b_in and mode_in changes during RUN SHALL have no effect.
REQ-020 Add: result_out = (a+b) mod 2^WIDTH, and cb_out SHALL be 1 if and only if a+b >= 2^WIDTH.
REQ-021 Subtract: result_out = (a-b) mod 2^WIDTH, and cb_out SHALL be 1 if and only if a < b (unsigned).
REQ-022 start_in held high continuously SHALL start a new operation on the IDLE cycle after each DONE.
REQ-023 result_out and cb_out SHALL keep their last values through IDLE and RUN until the next DONE.

Reset
REQ-024 rst_n_in=0 at a clock edge SHALL force IDLE and clear busy_out, done_out, result_out, cb_out, the counter, the operand registers and the carry/borrow flop.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done_out pulse.

Configuration
REQ-026 Macro SERIAL_ADDSUB_OVF_EN defined: the block SHALL add output ovf_out (1 bit), the signed two's-complement overflow of the operation, valid and held with result_out and cleared by reset.
REQ-027 Macro SERIAL_ADDSUB_OVF_EN undefined: the port ovf_out and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package/header serial_addsub_pkg SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the mode constants (MODE_ADD=1'b0, MODE_SUB=1'b1) and the default WIDTH.
REQ-029 A sub-module full_addsub_bit SHALL implement the 1-bit cell: inputs a, b, cb_in and mode; outputs s and cb_out. serial_addsub SHALL instantiate it exactly once.

Verification (WIDTH=8)
REQ-030 add 0x0F+0x01 -> result_out=0x10, cb_out=0, done_out pulse exactly 10 cycles after the start edge, busy_out high for 9 cycles.
REQ-031 add 0xFF+0x01 -> result_out=0x00, cb_out=1; with SERIAL_ADDSUB_OVF_EN, add 0x7F+0x01 -> result_out=0x80, ovf_out=1.
REQ-032 sub 0x05-0x03 -> result_out=0x02, cb_out=0; sub 0x03-0x05 -> result_out=0xFE, cb_out=1.
REQ-033 start add 0x01+0x01, pulse start_in with a_in=0xAA at RUN cycle 3 -> result_out=0x02, exactly one done_out pulse.
REQ-034 rst_n_in=0 for 1 cycle at RUN cycle 4 -> next cycle busy_out=0, result_out=0x00, cb_out=0, and no done_out pulse.
REQ-035 start_in held high for 3 operations -> three done_out pulses spaced WIDTH+2 = 10 cycles apart.
